// File: rtl/restoring_divn.sv
// rtl/restoring_divn.sv - sequential restoring divider, one quotient bit per cycle
// Signed operation is compiled in only when RESTORING_DIVN_SIGNED_EN is defined.
module restoring_divn #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] mag_d;
  logic             zero_div;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  logic [WIDTH:0]   a_sh;
  logic [WIDTH+1:0] trial;
  logic             trial_neg;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic             unused_trial_msb;

`ifdef RESTORING_DIVN_SIGNED_EN
  logic dvd_neg;
  logic dvs_neg;
  logic neg_q;
  logic neg_r;

  assign dvd_neg = signed_mode & dividend[WIDTH-1];
  assign dvs_neg = signed_mode & divisor[WIDTH-1];
  // Negating the most negative value yields the same bits, read here as 2^(WIDTH-1).
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor : divisor;
  assign q_fix   = neg_q ? -quo : quo;
  assign r_fix   = neg_r ? -acc : acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && start) begin
      neg_q <= dvd_neg ^ dvs_neg;
      neg_r <= dvd_neg;
    end
  end
`else
  logic unused_signed_mode;

  assign unused_signed_mode = signed_mode;
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign q_fix   = quo;
  assign r_fix   = acc;
`endif

  // The shifted partial remainder can reach 2*|divisor|-1, so it needs one extra bit.
  assign a_sh      = {acc, quo[WIDTH-1]};
  assign trial     = {1'b0, a_sh} - {2'b00, mag_d};
  assign trial_neg = trial[WIDTH+1];
  assign acc_nxt   = trial_neg ? a_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nxt   = {quo[WIDTH-2:0], ~trial_neg};
  assign unused_trial_msb = trial[WIDTH];

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      acc       <= '0;
      quo       <= '0;
      mag_d     <= '0;
      zero_div  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count <= '0;
            acc   <= '0;
            if (divisor == '0) begin
              // Keep the raw dividend so it can be returned as the remainder.
              zero_div <= 1'b1;
              quo      <= dividend;
              mag_d    <= '0;
              state    <= FIX;
            end else begin
              zero_div <= 1'b0;
              quo      <= dvd_mag;
              mag_d    <= dvs_mag;
              state    <= RUN;
            end
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          quo   <= quo_nxt;
          count <= count + 1'b1;
          if (count == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          quotient  <= zero_div ? '1 : q_fix;
          remainder <= zero_div ? quo : r_fix;
          div_zero  <= zero_div;
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divn.sv
// tb/tb_restoring_divn.sv - scoreboard bench for restoring_divn (WIDTH=8)
// Expected results follow RESTORING_DIVN_SIGNED_EN when the bench is built with it.
module tb_restoring_divn;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         signed_mode;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           acc;
    int           lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  restoring_divn #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_zero    (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic void model(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz);
    int  sa, sbv, iq, ir;
    bit  use_s;
    use_s = 1'b0;
`ifdef RESTORING_DIVN_SIGNED_EN
    use_s = sm;
`endif
    if (b == '0) begin
      q = '1; r = a; dz = 1'b1;
    end else begin
      dz = 1'b0;
      if (use_s) begin
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        iq  = sa / sbv;
        ir  = sa % sbv;
        q   = iq[W-1:0];
        r   = ir[W-1:0];
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  // Drive a request (caller is at a negedge with the DUT idle) and log its expected result.
  task automatic launch(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                        input bit hold);
    exp_t e;
    signed_mode = sm;
    dividend    = a;
    divisor     = b;
    start       = 1'b1;
    @(posedge clk);
    #1;
    e.q = eq; e.r = er; e.dz = edz; e.acc = cyc;
    e.lat = (b == '0) ? 1 : W + 1;
    sb.push_back(e);
    if (!hold) start = 1'b0;
  endtask

  task automatic launch_m(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r;
    logic         dz;
    model(sm, a, b, q, r, dz);
    launch(sm, a, b, q, r, dz, 1'b0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      check("done_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("quotient", quotient, mon_e.q);
        check("remainder", remainder, mon_e.r);
        check("div_zero", div_zero, mon_e.dz);
        check("latency", cyc - mon_e.acc, mon_e.lat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_div_zero", div_zero, 0);
    rst = 1'b1;
    @(negedge clk);

    // 100/7 with busy profile
    launch(1'b0, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0);
    for (int k = 0; k <= W; k++) begin
      @(negedge clk);
      check("busy_run", busy, 1);
    end
    @(negedge clk);
    check("busy_done", busy, 0);
    check("done_pulse", done, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("hold_quotient", quotient, 8'd14);
    wait_idle();

    // signed operands (unsigned interpretation when signed support is absent)
    launch_m(1'b1, 8'h9C, 8'h07);
    wait_idle();
    launch_m(1'b1, 8'd100, 8'hF9);
    wait_idle();
    launch_m(1'b1, 8'h80, 8'hFF);
    wait_idle();
    launch_m(1'b1, 8'h85, 8'h00);
    wait_idle();

    // divide by zero then recovery
    launch(1'b0, 8'h55, 8'h00, 8'hFF, 8'h55, 1'b1, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);
    check("dz_hold", div_zero, 1);
    launch(1'b0, 8'd8, 8'd2, 8'd4, 8'd0, 1'b0, 1'b0);
    wait_idle();
    check("dz_cleared", div_zero, 0);
    launch(1'b0, 8'd255, 8'd1, 8'hFF, 8'd0, 1'b0, 1'b0);
    wait_idle();

    // start held through busy, then back-to-back start in the done cycle
    launch(1'b0, 8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 1'b1);
    repeat (W + 1) @(negedge clk);
    dividend = 8'd77; divisor = 8'd3;
    @(negedge clk);
    check("held_done_cycle", done, 1);
    launch(1'b0, 8'd9, 8'd4, 8'd2, 8'd1, 1'b0, 1'b0);
    wait_idle();

    // reset in the middle of 200/3
    launch(1'b0, 8'd200, 8'd3, 8'd66, 8'd2, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_quotient", quotient, 0);
    check("mid_rst_remainder", remainder, 0);
    check("mid_rst_div_zero", div_zero, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (14) @(negedge clk);
    launch(1'b0, 8'd200, 8'd3, 8'd66, 8'd2, 1'b0, 1'b0);
    wait_idle();

    // random mix
    for (int n = 0; n < 24; n++) begin
      logic [W-1:0] a, b;
      logic         sm;
      a  = W'($urandom_range(0, 255));
      b  = (n % 8 == 7) ? '0 : W'($urandom_range(0, 255));
      sm = 1'($urandom_range(0, 1));
      launch_m(sm, a, b);
      wait_idle();
    end

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/restoring_divn.md
RESTORING_DIVN -- requirements
Module: restoring_divn

Interface
REQ-001 SHALL provide parameter: WIDTH, 8, operand/result width in bits (legal range 4..32).
REQ-002 SHALL provide port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL provide port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: start  input  1  request to begin a division, sampled on the rising edge of clk.
REQ-005 SHALL provide port: signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
REQ-006 SHALL provide port: dividend  input  WIDTH  numerator; captured with start.
REQ-007 SHALL provide port: divisor  input  WIDTH  denominator; captured with start.
REQ-008 SHALL provide port: quotient  output  WIDTH  registered result.
REQ-009 SHALL provide port: remainder  output  WIDTH  registered result.
REQ-010 SHALL provide port: busy  output  1  high while a division is in progress.
REQ-011 SHALL provide port: done  output  1  one-cycle pulse marking valid results.
REQ-012 SHALL provide port: div_zero  output  1  registered flag, set when the last completed division had divisor==0.

Function
REQ-013 SHALL use FSM states IDLE, RUN, FIX; IDLE->RUN on accepted start, RUN->FIX after WIDTH iterations, FIX->IDLE unconditionally; a zero divisor goes IDLE->FIX directly.
REQ-014 SHALL accept start only when busy==0; start while busy==1 is ignored with no effect on state or outputs.
REQ-015 SHALL capture the operand magnitudes on acceptance: in signed mode, negative operands are negated; the magnitude is an unsigned WIDTH-bit value, so -2^(WIDTH-1) maps to 2^(WIDTH-1).
REQ-016 SHALL perform one restoring iteration per RUN cycle: shift {A,Q} left by 1; trial = A - |divisor| using WIDTH+1 bits; if the trial is negative, restore A and set q_lsb=0, else keep the trial and set q_lsb=1.
REQ-017 SHALL apply sign correction in FIX: quotient is negated when sign(dividend)^sign(divisor) is 1; remainder takes the sign of the dividend; no correction is applied in unsigned mode.
REQ-018 SHALL follow this latency: with start accepted at edge 0, quotient, remainder, div_zero and done are updated at edge WIDTH+1, so done is high for exactly one cycle after that edge.
REQ-019 SHALL hold busy high from edge 0 and drop it at the edge where done rises.
REQ-020 SHALL accept a start presented during the done cycle, so back-to-back operations are possible.
REQ-021 SHALL handle divisor==0 as follows: done is asserted after edge 1; quotient = all ones; remainder = raw dividend; div_zero = 1.
REQ-022 SHALL handle signed -2^(WIDTH-1) / -1 by returning quotient = -2^(WIDTH-1) (wrap) and remainder = 0, with no error flag.
REQ-023 SHALL hold quotient, remainder and div_zero stable between done pulses; div_zero is cleared by the next non-zero-divisor completion.

Reset
REQ-024 SHALL respond to rst low, at any time including mid-operation, by immediately forcing state=IDLE, busy=0, done=0, div_zero=0, quotient=0, remainder=0, and clearing the iteration counter and working registers.
REQ-025 SHALL NOT produce a done pulse for an operation interrupted by reset; the first start after rst release is accepted normally.

Configuration
REQ-026 SHALL support macro RESTORING_DIVN_SIGNED_EN: when defined, signed_mode is honoured per REQ-015/017/022.
REQ-027 SHALL, when RESTORING_DIVN_SIGNED_EN is undefined, keep the signed_mode port but ignore it, operate unsigned only, and synthesise no negation or sign-fix logic; latency is unchanged.

Verification (WIDTH=8)
REQ-028 SHALL cover unsigned: 100/7, start at edge 0 -> done after edge 9, quotient=14 (0x0E), remainder=2, div_zero=0, busy high for edges 0..8.
REQ-029 SHALL cover signed (with RESTORING_DIVN_SIGNED_EN): -100/7 (0x9C/0x07) -> quotient=0xF2 (-14), remainder=0xFE (-2); and 100/-7 -> quotient=0xF2, remainder=0x02.
REQ-030 SHALL cover divide by zero: 0x55/0x00 -> done after edge 1, quotient=0xFF, remainder=0x55, div_zero=1; a following 8/2 completes with div_zero=0, quotient=4.
REQ-031 SHALL cover signed boundary: -128/-1 (0x80/0xFF) -> quotient=0x80, remainder=0x00; unsigned 255/1 -> quotient=0xFF, remainder=0.
REQ-032 SHALL cover the handshake: start with 50/5 held high throughout busy -> single done with quotient=10, results unchanged by ignored starts; start in the done cycle with 9/4 -> second done 9 cycles later, quotient=2, remainder=1.
REQ-033 SHALL cover reset mid-operation: rst pulsed low at edge 4 of 200/3 -> all outputs 0 immediately and no done pulse; the next start with 200/3 yields quotient=66, remainder=2.
